// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the architectural PC, issues one imem request at a time,
// holds the returned instruction for decode and applies taken redirects from decode/execute.
package fetch_pc_pkg;
  typedef enum logic {
    PC_INPUT_PC_PLUS_4 = 1'b0,
    PC_INPUT_ALU       = 1'b1
  } pc_input_sel_t;
endpackage

module fetch_pc_sequencer
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  pc_input_sel_t redirect_sel,
  input  logic [31:0]   redirect_target,
  output logic          misaligned_fault,
  output logic [2:0]    state_dbg
);

  // Handshakes: imem request transfers on a cycle with imem_req_valid && imem_req_ready;
  // addr holds while valid && !ready except when a taken redirect retargets the pending request.
  // Decode owns instr while instr_valid; it is consumed on a cycle with instr_valid && instr_ready.
  // Exactly one imem_rsp_valid pulse follows each accepted request.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        taken;

  assign taken          = redirect_valid && (redirect_sel == PC_INPUT_ALU);
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_VECTOR;
      instr            <= 32'h0;
      instr_pc         <= 32'h0;
      instr_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
    end else if (state != FAULT && taken) begin
      instr_valid <= 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        misaligned_fault <= 1'b1;
        state            <= FAULT;
      end else begin
        pc <= redirect_target;
        // An in-flight request to the old PC leaves one response to discard.
        case (state)
          REQ:        state <= imem_req_ready ? DROP : REQ;
          WAIT, DROP: state <= imem_rsp_valid ? REQ : DROP;
          default:    state <= REQ;
        endcase
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: imem responder model, scoreboard of expected fetch
// addresses and delivered {instr_pc, instr}, directed scenarios and a wrap-around instance.
module tb_fetch_pc_sequencer;
  import fetch_pc_pkg::*;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid, req_ready, rsp_valid, instr_valid, instr_ready;
  logic [31:0]   req_addr, rsp_data, instr, instr_pc, redirect_target;
  logic          redirect_valid, fault;
  pc_input_sel_t redirect_sel;
  logic [2:0]    state_dbg;

  logic          w_reset, w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready;
  logic [31:0]   w_req_addr, w_rsp_data, w_instr, w_instr_pc;
  logic          w_fault;
  logic [2:0]    w_state;

  fetch_pc_sequencer #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .redirect_target(redirect_target), .misaligned_fault(fault), .state_dbg(state_dbg)
  );

  fetch_pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_ready(w_instr_ready), .redirect_valid(1'b0), .redirect_sel(PC_INPUT_PC_PLUS_4),
    .redirect_target(32'h0), .misaligned_fault(w_fault), .state_dbg(w_state)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] w_addrs[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rsp_lat  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic expect_fetch(input logic [31:0] a);
    addr_q.push_back(a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready && addr_q.size() > 0)
        check_eq("req_addr", {32'h0, req_addr}, {32'h0, addr_q.pop_front()});
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check_eq("instr_unexpected", {32'h0, instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check_eq("instr", {instr_pc, instr}, exp_q.pop_front());
      end
    end
    if (!w_reset && w_req_valid && w_req_ready && w_addrs.size() < 2) w_addrs.push_back(w_req_addr);
  end

  // imem responders: one response rsp_lat cycles after the accept cycle
  initial begin
    logic [31:0] a;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (req_valid && req_ready && !reset) begin
        a = req_addr;
        @(posedge clk); #1;
        repeat (rsp_lat) begin @(posedge clk); #1; end
        rsp_valid = 1'b1;
        rsp_data  = mem_word(a);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (w_req_valid && w_req_ready && !w_reset) begin
        a = w_req_addr;
        @(posedge clk); #1;
        w_rsp_valid = 1'b1;
        w_rsp_data  = mem_word(a);
        @(posedge clk); #1;
        w_rsp_valid = 1'b0;
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_dut();
    reset           = 1'b1;
    req_ready       = 1'b1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_sel    = PC_INPUT_PC_PLUS_4;
    redirect_target = 32'h0;
    step(3);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic wait_drain(input int budget, output int t);
    t = 0;
    while ((exp_q.size() + addr_q.size()) != 0 && t < budget) begin step(); t++; end
    check_eq("drain", 64'(exp_q.size() + addr_q.size()), 64'd0);
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int t = 0;
    while (!(req_valid && req_addr == a) && t < 60) begin step(); t++; end
    check_eq("wait_req", {31'h0, req_valid, req_addr}, {31'h0, 1'b1, a});
  endtask

  task automatic consume_one(input int hold, input logic [31:0] pc);
    int t = 0;
    while (!instr_valid && t < 30) begin step(); t++; end
    check_eq("consume_valid", 64'(instr_valid), 64'd1);
    for (int k = 0; k < hold; k++) begin
      check_eq("hold_instr", {instr_pc, instr}, {pc, mem_word(pc)});
      check_eq("hold_no_req", 64'(req_valid), 64'd0);
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  initial begin
    int t;
    logic [31:0] a0, a1;
    w_reset       = 1'b1;
    w_req_ready   = 1'b1;
    w_instr_ready = 1'b1;
    reset_dut();

    // reset state
    check_eq("rst_req_valid", 64'(req_valid), 64'd0);
    check_eq("rst_addr", 64'(req_addr), 64'h100);
    check_eq("rst_instr", {instr_pc, instr}, 64'd0);
    check_eq("rst_outputs", {62'd0, instr_valid, fault}, 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check_eq("wrap_rst_addr", 64'(w_req_addr), 64'hFFFF_FFFC);
    w_reset = 1'b0;

    // sequential fetch, zero-wait imem, 3 cycles per instruction
    expect_fetch(32'h100); expect_fetch(32'h104); expect_fetch(32'h108);
    reset = 1'b0;
    check_eq("idle_after_release", 64'(state_dbg), 64'(ST_IDLE));
    wait_drain(40, t);
    check_eq("seq_cycles", 64'(t), 64'd10);

    // request stalled by imem for 3 cycles
    reset_dut();
    req_ready = 1'b0;
    expect_fetch(32'h100); expect_fetch(32'h104);
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req", {31'h0, req_valid, req_addr}, {31'h0, 1'b1, 32'h100});
      step();
    end
    req_ready = 1'b1;
    check_eq("stall_req_last", {31'h0, req_valid, req_addr}, {31'h0, 1'b1, 32'h100});
    step();
    check_eq("stall_to_wait", 64'(state_dbg), 64'(ST_WAIT));
    wait_drain(40, t);

    // decode back-pressure on the second instruction
    reset_dut();
    instr_ready = 1'b0;
    expect_fetch(32'h100); expect_fetch(32'h104); expect_fetch(32'h108);
    reset = 1'b0;
    consume_one(0, 32'h100);
    consume_one(2, 32'h104);
    consume_one(0, 32'h108);
    wait_drain(10, t);

    // taken redirect while waiting on a slow response
    reset_dut();
    rsp_lat = 2;
    expect_fetch(32'h100); expect_fetch(32'h104); addr_q.push_back(32'h108);
    expect_fetch(32'h200); expect_fetch(32'h204);
    reset = 1'b0;
    wait_addr(32'h108);
    step();
    check_eq("redir_wait_state", 64'(state_dbg), 64'(ST_WAIT));
    redirect_valid = 1'b1; redirect_sel = PC_INPUT_ALU; redirect_target = 32'h200;
    step();
    redirect_valid = 1'b0;
    check_eq("redir_drop_state", 64'(state_dbg), 64'(ST_DROP));
    wait_drain(80, t);

    // taken redirect in the same cycle as the response
    reset_dut();
    rsp_lat = 0;
    expect_fetch(32'h100); expect_fetch(32'h104); addr_q.push_back(32'h108);
    expect_fetch(32'h200); expect_fetch(32'h204);
    reset = 1'b0;
    wait_addr(32'h108);
    step();
    redirect_valid = 1'b1; redirect_sel = PC_INPUT_ALU; redirect_target = 32'h200;
    step();
    redirect_valid = 1'b0;
    check_eq("redir_direct_req", {29'h0, state_dbg, req_addr}, {29'h0, ST_REQ, 32'h200});
    wait_drain(40, t);

    // not-taken redirect held in every state changes nothing
    reset_dut();
    redirect_valid = 1'b1; redirect_sel = PC_INPUT_PC_PLUS_4;
    redirect_target = 32'h300 | 32'($urandom_range(0, 3));
    expect_fetch(32'h100); expect_fetch(32'h104); expect_fetch(32'h108);
    reset = 1'b0;
    wait_drain(40, t);
    check_eq("nt_cycles", 64'(t), 64'd10);
    check_eq("nt_no_fault", 64'(fault), 64'd0);

    // misaligned taken redirect: sticky fault until reset
    reset_dut();
    expect_fetch(32'h100);
    reset = 1'b0;
    wait_drain(20, t);
    redirect_valid = 1'b1; redirect_sel = PC_INPUT_ALU; redirect_target = 32'h202;
    step();
    check_eq("fault_flag", {61'd0, fault, instr_valid, req_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
    check_eq("fault_state", 64'(state_dbg), 64'(ST_FAULT));
    redirect_target = 32'h400;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("fault_sticky", {30'd0, fault, req_valid, req_addr}, {30'd0, 1'b1, 1'b0, 32'h104});
    end
    reset_dut();
    check_eq("fault_cleared", 64'(fault), 64'd0);

    // wrap-around instance: fetch after 0xFFFF_FFFC goes to 0
    a0 = (w_addrs.size() > 0) ? w_addrs[0] : 32'hDEAD_BEEF;
    a1 = (w_addrs.size() > 1) ? w_addrs[1] : 32'hDEAD_BEEF;
    check_eq("wrap_first", 64'(a0), 64'hFFFF_FFFC);
    check_eq("wrap_second", 64'(a1), 64'h0);
    check_eq("wrap_no_fault", 64'(w_fault), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
